multdiv_fast: RTL and testbench
===============================

// Module: multdiv_fast
// PURPOSE
// RV32M multiply/divide unit beside the ALU in the ibex execute stage. Multiplies in one
// cycle (MUL) or two cycles (MULH*). Divides with a 37-cycle restoring long-division FSM.
// The FSM borrows the shared ALU adder and keeps intermediate state in external imd_val registers.
// PARAMETERS
// RV32M  ibex_pkg::rv32m_e  default RV32MSingleCycle  multiplier flavour; RV32MFast is also accepted
//   and behaves identically here.
// PORTS
// clk_i              in   1     clock; all state updates on the rising edge
// rst_i              in   1     reset: synchronous, active-high
// mult_en_i          in   1     multiply operation active (held until result consumed)
// div_en_i           in   1     divide operation active (held until result consumed)
// mult_sel_i         in   1     result mux select: multiplier
// div_sel_i          in   1     result mux select: divider
// operator_i         in   md_op_e  MD_OP_MULL/MULH/DIV/REM
// signed_mode_i      in   2     [0]=op_a signed, [1]=op_b signed
// op_a_i, op_b_i     in   32    operands
// alu_adder_ext_i    in   34    external sum {1'b0,alu_operand_a_o}+{1'b0,alu_operand_b_o}
// alu_adder_i        in   32    alu_adder_ext_i[32:1]
// equal_to_zero_i    in   1     op_b_i == 0
// data_ind_timing_i  in   1     1 = data-independent timing; disables the div-by-zero shortcut
// alu_operand_a_o    out  33    ALU adder operand A
// alu_operand_b_o    out  33    ALU adder operand B
// imd_val_q_i[2]     in   2x34  registered intermediate values (external flops)
// imd_val_d_o[2]     out  2x34  next intermediate values
// imd_val_we_o       out  2     write enables for imd_val[1:0]
// multdiv_ready_id_i in   1     ID stage accepts the result
// multdiv_result_o   out  32    result
// valid_o            out  1     result valid
// BEHAVIOUR
// - Reset (rst_i=1 at a clock edge): div FSM to MD_IDLE, mult FSM to idle, counters 0.
//   Outputs in reset: valid_o=0, imd_val_we_o=0, imd_val_d_o=0, operands 0.
// - Multiply: operands sign- or zero-extended to 33b per signed_mode_i; 33x33 signed product.
//   MULL: low 32 bits; valid_o combinational in the cycle mult_en_i is asserted.
//   MULH (signed_mode 11/01/00 = MULH/MULHSU/MULHU): high 32 bits.
//     Cycle 0: write the partial into imd_val[0] (we=01), valid_o=0.
//     Cycle 1: valid_o=1.
//     Return to idle when multdiv_ready_id_i=1 or mult_en_i drops.
// - Divide (DIV/REM; signed if signed_mode_i!=0). FSM and cycle of each state after div_en_i rises:
//     MD_IDLE(0) -> MD_ABS_A(1) -> MD_ABS_B(2) -> MD_COMP(3..33, 31 cycles)
//     -> MD_LAST(34) -> MD_CHANGE_SIGN(35) -> MD_FINISH(36).
//   valid_o=1 only in MD_FINISH. Leave MD_FINISH to MD_IDLE when multdiv_ready_id_i=1.
//   ABS_A/ABS_B: negate negative signed operands through the adder
//     (alu_operand_a_o = {~x,1}, alu_operand_b_o = {0,1}).
//   Quotient and remainder live in imd_val[0]/[1]; divisor shift in a local register.
//   COMP/LAST step: alu_operand_a_o={rem_shifted,1}, alu_operand_b_o={~divisor,1}, so alu_adder_i = rem-div.
//     If rem>=div: rem<=alu_adder_i and shift 1 into the quotient; else shift 0.
//   CHANGE_SIGN negates quotient when sign(a)^sign(b), and negates the remainder when sign(a).
// - Divide by zero: DIV=32'hFFFFFFFF, REM=op_a_i.
//   If data_ind_timing_i=0, MD_IDLE jumps straight to MD_FINISH (valid at cycle 1).
// - Signed overflow: -2^31 / -1 gives quotient 0x80000000, remainder 0.
// - Dropping div_en_i mid-operation returns the FSM to MD_IDLE next cycle; no result is produced.
// - multdiv_result_o muxed by mult_sel_i/div_sel_i; 0 when neither is selected.
// TESTING
// MULL 10*3, signed_mode 00 -> result 30, valid_o the same cycle
// MULL -12*5 and 1000*-2, mode 11 -> -60, -2000; 1000*0 -> 0
// DIV 100/5, mode 00 -> 20 after 37 cycles; DIV -50/7, mode 11 -> -7; REM -50%7 -> -1
// DIV 42/0, mode 00, data_ind_timing_i=0 -> 0xFFFFFFFF at cycle 1; with data_ind_timing_i=1 -> same result at cycle 36
// DIV 0/42 -> 0; DIV 147/147 -> 1; DIV 0x80000000/-1, mode 11 -> 0x80000000
// Reset asserted in MD_COMP -> valid_o=0, FSM in MD_IDLE next cycle; new DIV afterwards is correct

Source files
------------

// File: rtl/multdiv_fast.sv
// RV32M multiply/divide unit for the ibex execute stage: single-cycle MUL, two-cycle MULH*,
// and a restoring long divider that borrows the ALU adder and the external imd_val flops.
package ibex_pkg;
   typedef enum logic [1:0] {RV32MNone, RV32MSlow, RV32MFast, RV32MSingleCycle} rv32m_e;
   typedef enum logic [1:0] {MD_OP_MULL, MD_OP_MULH, MD_OP_DIV, MD_OP_REM} md_op_e;
endpackage

// state          | meaning
// MD_IDLE        | waiting for div_en_i; div-by-zero shortcut goes straight to MD_FINISH
// MD_ABS_A       | |op_a| through the adder into numerator
// MD_ABS_B       | |op_b| through the adder into divisor, clear quotient/remainder
// MD_COMP        | 31 shift-subtract steps, counted down by div_counter
// MD_LAST        | final (32nd) shift-subtract step
// MD_CHANGE_SIGN | apply result signs to quotient and remainder
// MD_FINISH      | result valid until the ID stage accepts it
// MULT_IDLE      | MULL answers here; MULH stores its low partial product
// MULT_HIGH      | MULH result valid
module multdiv_fast
   import ibex_pkg::*;
#(
   parameter rv32m_e RV32M = RV32MSingleCycle
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        mult_en_i,
   input  logic        div_en_i,
   input  logic        mult_sel_i,
   input  logic        div_sel_i,
   input  md_op_e      operator_i,
   input  logic [1:0]  signed_mode_i,
   input  logic [31:0] op_a_i,
   input  logic [31:0] op_b_i,
   input  logic [33:0] alu_adder_ext_i,
   input  logic [31:0] alu_adder_i,
   input  logic        equal_to_zero_i,
   input  logic        data_ind_timing_i,
   output logic [32:0] alu_operand_a_o,
   output logic [32:0] alu_operand_b_o,
   input  logic [33:0] imd_val_q_i [2],
   output logic [33:0] imd_val_d_o [2],
   output logic [1:0]  imd_val_we_o,
   input  logic        multdiv_ready_id_i,
   output logic [31:0] multdiv_result_o,
   output logic        valid_o
);

   typedef enum logic [2:0] {
      MD_IDLE, MD_ABS_A, MD_ABS_B, MD_COMP, MD_LAST, MD_CHANGE_SIGN, MD_FINISH
   } md_fsm_e;

   typedef enum logic {MULT_IDLE, MULT_HIGH} mult_fsm_e;

   // Both accepted flavours share the same two-cycle MULH datapath.
   localparam logic FastMul = (RV32M == RV32MFast) || (RV32M == RV32MSingleCycle);

   md_fsm_e     md_state_q, md_state_d;
   mult_fsm_e   mult_state_q, mult_state_d;
   logic [4:0]  div_counter_q, div_counter_d;
   logic [31:0] numerator_q, numerator_d;
   logic [31:0] divisor_q, divisor_d;

   logic        div_signed, sign_a, sign_b, neg_quot, div_by_zero_fast;
   logic [31:0] quot_q, rem_q;
   logic [32:0] rem_shifted;
   logic        rem_ge_div;
   logic [31:0] rem_next;

   logic [32:0] div_operand_a, div_operand_b;
   logic [33:0] div_imd_d [2];
   logic [1:0]  div_we;
   logic        div_valid;
   logic        mult_we;
   logic        mult_valid;

   logic signed [32:0] a_ext, b_ext;
   logic signed [49:0] a_wide, mulh_lo_prod, mulh_hi_prod, mulh_sum;
   logic [33:0] mulh_partial;
   logic [31:0] mulh_result, mull_result;

   // ---------------------------------------------------------------- multiplier datapath
   assign a_ext        = {signed_mode_i[0] & op_a_i[31], op_a_i};
   assign b_ext        = {signed_mode_i[1] & op_b_i[31], op_b_i};
   assign a_wide       = {{17{a_ext[32]}}, a_ext};
   assign mull_result  = op_a_i * op_b_i;

   // MULH splits b into a 16-bit unsigned low half and a signed 17-bit high half;
   // the low partial product, pre-shifted by 16, waits in imd_val[0] for the second cycle.
   assign mulh_lo_prod = a_wide * $signed({34'b0, b_ext[15:0]});
   assign mulh_partial = mulh_lo_prod[49:16];
   assign mulh_hi_prod = a_wide * $signed({{33{b_ext[32]}}, b_ext[32:16]});
   assign mulh_sum     = mulh_hi_prod + $signed({{16{imd_val_q_i[0][33]}}, imd_val_q_i[0]});
   assign mulh_result  = mulh_sum[47:16];

   // ---------------------------------------------------------------- divider datapath
   assign div_signed       = |signed_mode_i;
   assign sign_a           = div_signed & op_a_i[31];
   assign sign_b           = div_signed & op_b_i[31];
   assign neg_quot         = (sign_a ^ sign_b) & ~equal_to_zero_i;
   assign div_by_zero_fast = equal_to_zero_i & ~data_ind_timing_i;
   assign quot_q           = imd_val_q_i[0][31:0];
   assign rem_q            = imd_val_q_i[1][31:0];

   // The shifted remainder can reach 33 bits for unsigned operands; its top bit alone
   // guarantees rem >= divisor, otherwise the adder carry-out decides.
   assign rem_shifted = {rem_q, numerator_q[31]};
   assign rem_ge_div  = rem_shifted[32] | alu_adder_ext_i[33];
   assign rem_next    = rem_ge_div ? alu_adder_i : rem_shifted[31:0];

   // ---------------------------------------------------------------- state registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         md_state_q    <= MD_IDLE;
         mult_state_q  <= MULT_IDLE;
         div_counter_q <= '0;
         numerator_q   <= '0;
         divisor_q     <= '0;
      end else begin
         md_state_q    <= md_state_d;
         mult_state_q  <= mult_state_d;
         div_counter_q <= div_counter_d;
         numerator_q   <= numerator_d;
         divisor_q     <= divisor_d;
      end
   end

   // ---------------------------------------------------------------- divider next state
   always_comb begin
      md_state_d = md_state_q;
      unique case (md_state_q)
         MD_IDLE: begin
            if (div_en_i) begin
               md_state_d = div_by_zero_fast ? MD_FINISH : MD_ABS_A;
            end
         end
         MD_ABS_A:       md_state_d = MD_ABS_B;
         MD_ABS_B:       md_state_d = MD_COMP;
         MD_COMP: begin
            if (div_counter_q == 5'd0) begin
               md_state_d = MD_LAST;
            end
         end
         MD_LAST:        md_state_d = MD_CHANGE_SIGN;
         MD_CHANGE_SIGN: md_state_d = MD_FINISH;
         MD_FINISH: begin
            if (multdiv_ready_id_i) begin
               md_state_d = MD_IDLE;
            end
         end
         default:        md_state_d = MD_IDLE;
      endcase
      if (!div_en_i) begin
         md_state_d = MD_IDLE;
      end
   end

   always_comb begin
      div_counter_d = div_counter_q;
      numerator_d   = numerator_q;
      divisor_d     = divisor_q;
      unique case (md_state_q)
         MD_ABS_A: numerator_d = sign_a ? alu_adder_i : op_a_i;
         MD_ABS_B: begin
            divisor_d     = sign_b ? alu_adder_i : op_b_i;
            div_counter_d = 5'd30;
         end
         MD_COMP: begin
            numerator_d = {numerator_q[30:0], 1'b0};
            if (div_counter_q != 5'd0) begin
               div_counter_d = div_counter_q - 5'd1;
            end
         end
         MD_LAST:  numerator_d = {numerator_q[30:0], 1'b0};
         default:  ;
      endcase
   end

   // ---------------------------------------------------------------- divider outputs
   always_comb begin
      div_operand_a = '0;
      div_operand_b = '0;
      div_imd_d[0]  = '0;
      div_imd_d[1]  = '0;
      div_we        = 2'b00;
      div_valid     = 1'b0;
      unique case (md_state_q)
         MD_IDLE: begin
            if (div_en_i && div_by_zero_fast) begin
               div_imd_d[0] = {2'b00, 32'hFFFF_FFFF};
               div_imd_d[1] = {2'b00, op_a_i};
               div_we       = 2'b11;
            end
         end
         MD_ABS_A: begin
            div_operand_a = {~op_a_i, 1'b1};
            div_operand_b = {32'b0, 1'b1};
         end
         MD_ABS_B: begin
            div_operand_a = {~op_b_i, 1'b1};
            div_operand_b = {32'b0, 1'b1};
            div_we        = 2'b11;
         end
         MD_COMP, MD_LAST: begin
            div_operand_a = {rem_shifted[31:0], 1'b1};
            div_operand_b = {~divisor_q, 1'b1};
            div_imd_d[0]  = {2'b00, quot_q[30:0], rem_ge_div};
            div_imd_d[1]  = {2'b00, rem_next};
            div_we        = 2'b11;
         end
         MD_CHANGE_SIGN: begin
            div_operand_a = {~quot_q, 1'b1};
            div_operand_b = {32'b0, 1'b1};
            div_imd_d[0]  = {2'b00, neg_quot ? alu_adder_i : quot_q};
            div_imd_d[1]  = {2'b00, sign_a ? (~rem_q + 32'd1) : rem_q};
            div_we        = 2'b11;
         end
         MD_FINISH: div_valid = 1'b1;
         default:   ;
      endcase
   end

   // ---------------------------------------------------------------- multiplier FSM
   always_comb begin
      mult_state_d = mult_state_q;
      unique case (mult_state_q)
         MULT_IDLE: begin
            if (mult_en_i && operator_i == MD_OP_MULH && FastMul) begin
               mult_state_d = MULT_HIGH;
            end
         end
         MULT_HIGH: begin
            if (multdiv_ready_id_i || !mult_en_i) begin
               mult_state_d = MULT_IDLE;
            end
         end
         default: mult_state_d = MULT_IDLE;
      endcase
   end

   always_comb begin
      mult_we    = 1'b0;
      mult_valid = 1'b0;
      unique case (mult_state_q)
         MULT_IDLE: begin
            if (mult_en_i) begin
               if (operator_i == MD_OP_MULH) begin
                  mult_we = 1'b1;
               end else begin
                  mult_valid = 1'b1;
               end
            end
         end
         MULT_HIGH: mult_valid = mult_en_i;
         default:   ;
      endcase
   end

   // ---------------------------------------------------------------- output merge
   always_comb begin
      alu_operand_a_o = '0;
      alu_operand_b_o = '0;
      imd_val_d_o[0]  = '0;
      imd_val_d_o[1]  = '0;
      imd_val_we_o    = 2'b00;
      valid_o         = 1'b0;
      if (!rst_i) begin
         alu_operand_a_o = div_operand_a;
         alu_operand_b_o = div_operand_b;
         imd_val_d_o[0]  = mult_we ? mulh_partial : div_imd_d[0];
         imd_val_d_o[1]  = div_imd_d[1];
         imd_val_we_o    = div_we | {1'b0, mult_we};
         valid_o         = div_valid | mult_valid;
      end
   end

   always_comb begin
      multdiv_result_o = '0;
      if (mult_sel_i) begin
         multdiv_result_o = (operator_i == MD_OP_MULL) ? mull_result : mulh_result;
      end else if (div_sel_i) begin
         multdiv_result_o = (operator_i == MD_OP_DIV) ? quot_q : rem_q;
      end
   end

   logic unused_bits;
   assign unused_bits = ^{alu_adder_ext_i[32:0], imd_val_q_i[1][33:32], mulh_lo_prod[15:0],
                          mulh_sum[49:48], mulh_sum[15:0], FastMul};

endmodule

// File: tb/tb_multdiv_fast.sv
// Self-checking bench for multdiv_fast: models the ALU adder and imd_val flops around the
// unit and compares against plain-arithmetic RV32M reference functions.
module tb_multdiv_fast;
   import ibex_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        mult_en_i = 1'b0;
   logic        div_en_i = 1'b0;
   logic        mult_sel_i = 1'b0;
   logic        div_sel_i = 1'b0;
   md_op_e      operator_i = MD_OP_MULL;
   logic [1:0]  signed_mode_i = 2'b00;
   logic [31:0] op_a_i = '0;
   logic [31:0] op_b_i = '0;
   logic [33:0] alu_adder_ext_i;
   logic [31:0] alu_adder_i;
   logic        equal_to_zero_i;
   logic        data_ind_timing_i = 1'b0;
   logic [32:0] alu_operand_a_o, alu_operand_b_o;
   logic [33:0] imd_q [2];
   logic [33:0] imd_d [2];
   logic [1:0]  imd_val_we_o;
   logic        multdiv_ready_id_i = 1'b0;
   logic [31:0] multdiv_result_o;
   logic        valid_o;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk_i = ~clk_i;

   assign alu_adder_ext_i = {1'b0, alu_operand_a_o} + {1'b0, alu_operand_b_o};
   assign alu_adder_i     = alu_adder_ext_i[32:1];
   assign equal_to_zero_i = (op_b_i == 32'd0);

   always @(posedge clk_i) begin
      if (imd_val_we_o[0]) imd_q[0] <= imd_d[0];
      if (imd_val_we_o[1]) imd_q[1] <= imd_d[1];
   end

   multdiv_fast #(.RV32M(RV32MSingleCycle)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .mult_en_i(mult_en_i), .div_en_i(div_en_i),
      .mult_sel_i(mult_sel_i), .div_sel_i(div_sel_i), .operator_i(operator_i),
      .signed_mode_i(signed_mode_i), .op_a_i(op_a_i), .op_b_i(op_b_i),
      .alu_adder_ext_i(alu_adder_ext_i), .alu_adder_i(alu_adder_i),
      .equal_to_zero_i(equal_to_zero_i), .data_ind_timing_i(data_ind_timing_i),
      .alu_operand_a_o(alu_operand_a_o), .alu_operand_b_o(alu_operand_b_o),
      .imd_val_q_i(imd_q), .imd_val_d_o(imd_d), .imd_val_we_o(imd_val_we_o),
      .multdiv_ready_id_i(multdiv_ready_id_i), .multdiv_result_o(multdiv_result_o),
      .valid_o(valid_o)
   );

   function automatic logic [31:0] ref_mul(logic [1:0] mode, logic [31:0] a, logic [31:0] b,
                                           logic high);
      logic signed [65:0] ea, eb, p;
      ea = mode[0] ? {{34{a[31]}}, a} : {34'b0, a};
      eb = mode[1] ? {{34{b[31]}}, b} : {34'b0, b};
      p  = ea * eb;
      return high ? p[63:32] : p[31:0];
   endfunction

   function automatic logic [31:0] ref_div(md_op_e op, logic [1:0] mode, logic [31:0] a,
                                           logic [31:0] b);
      longint sa, sb, q, r;
      if (b == 32'd0) return (op == MD_OP_DIV) ? 32'hFFFF_FFFF : a;
      if (mode != 2'b00) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'b0, a});
         sb = longint'({32'b0, b});
      end
      q = sa / sb;
      r = sa % sb;
      return (op == MD_OP_DIV) ? q[31:0] : r[31:0];
   endfunction

   task automatic idle_inputs();
      mult_en_i = 1'b0; div_en_i = 1'b0; mult_sel_i = 1'b0; div_sel_i = 1'b0;
      multdiv_ready_id_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      idle_inputs();
      repeat (2) @(posedge clk_i);
      #1;
      operator_i = MD_OP_MULH; mult_en_i = 1'b1; mult_sel_i = 1'b1;
      op_a_i = 32'h1234_5678; op_b_i = 32'h9ABC_DEF0; signed_mode_i = 2'b11;
      @(negedge clk_i);
      n_checks++;
      if (imd_val_we_o !== 2'b00 || imd_d[0] !== 34'd0 || valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mulh: we=%b d0=%h valid=%b, required we=00 d0=0 valid=0",
                  imd_val_we_o, imd_d[0], valid_o);
      end
      @(posedge clk_i); #1;
      operator_i = MD_OP_MULL;
      @(negedge clk_i);
      n_checks++;
      if (valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mull_valid: valid=%b, required 0", valid_o);
      end
      @(posedge clk_i); #1;
      mult_en_i = 1'b0; mult_sel_i = 1'b0;
      operator_i = MD_OP_DIV; div_en_i = 1'b1; op_b_i = 32'd0; data_ind_timing_i = 1'b0;
      @(negedge clk_i);
      n_checks++;
      if (imd_val_we_o !== 2'b00 || imd_d[1] !== 34'd0 || alu_operand_a_o !== 33'd0
          || alu_operand_b_o !== 33'd0 || valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_div: we=%b d1=%h opa=%h opb=%h valid=%b, required all 0",
                  imd_val_we_o, imd_d[1], alu_operand_a_o, alu_operand_b_o, valid_o);
      end
      @(posedge clk_i); #1;
      idle_inputs();
      rst_i = 1'b0;
      @(posedge clk_i); #1;
   endtask

   task automatic do_mull(input logic [1:0] mode, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] exp;
      exp = ref_mul(mode, a, b, 1'b0);
      @(posedge clk_i); #1;
      operator_i = MD_OP_MULL; signed_mode_i = mode; op_a_i = a; op_b_i = b;
      mult_en_i = 1'b1; mult_sel_i = 1'b1; multdiv_ready_id_i = 1'b1;
      @(negedge clk_i);
      n_checks++;
      if (valid_o !== 1'b1 || multdiv_result_o !== exp) begin
         n_fail++;
         $display("FAIL mull %h*%h m%b: valid=%b result=%h, required valid=1 result=%h",
                  a, b, mode, valid_o, multdiv_result_o, exp);
      end
      @(posedge clk_i); #1;
      idle_inputs();
   endtask

   task automatic do_mulh(input logic [1:0] mode, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] exp;
      exp = ref_mul(mode, a, b, 1'b1);
      @(posedge clk_i); #1;
      operator_i = MD_OP_MULH; signed_mode_i = mode; op_a_i = a; op_b_i = b;
      mult_en_i = 1'b1; mult_sel_i = 1'b1; multdiv_ready_id_i = 1'b0;
      @(negedge clk_i);
      n_checks++;
      if (valid_o !== 1'b0 || imd_val_we_o !== 2'b01) begin
         n_fail++;
         $display("FAIL mulh_cycle0 %h*%h: valid=%b we=%b, required valid=0 we=01",
                  a, b, valid_o, imd_val_we_o);
      end
      @(negedge clk_i);
      n_checks++;
      if (valid_o !== 1'b1 || multdiv_result_o !== exp) begin
         n_fail++;
         $display("FAIL mulh %h*%h m%b: valid=%b result=%h, required valid=1 result=%h",
                  a, b, mode, valid_o, multdiv_result_o, exp);
      end
      @(posedge clk_i); #1;
      idle_inputs();
   endtask

   task automatic test_mull();
      logic [1:0] mode;
      do_mull(2'b00, 32'd10, 32'd3);
      do_mull(2'b11, -32'sd12, 32'd5);
      do_mull(2'b11, 32'd1000, -32'sd2);
      do_mull(2'b11, 32'd1000, 32'd0);
      for (int i = 0; i < 12; i++) begin
         mode = 2'($urandom_range(0, 3));
         do_mull(mode, $urandom, $urandom);
      end
   endtask

   task automatic test_mulh();
      logic [1:0] modes [3];
      modes[0] = 2'b11; modes[1] = 2'b01; modes[2] = 2'b00;
      do_mulh(2'b11, 32'h8000_0000, 32'h8000_0000);
      do_mulh(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      do_mulh(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      do_mulh(2'b11, 32'hFFFF_FFFF, 32'h0000_0001);
      for (int i = 0; i < 15; i++) begin
         do_mulh(modes[i % 3], $urandom, $urandom);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a, b, exp;
      // MULL results follow the operands every cycle while mult_en_i stays high
      @(posedge clk_i); #1;
      operator_i = MD_OP_MULL; signed_mode_i = 2'b11; mult_en_i = 1'b1; mult_sel_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         a = $urandom; b = $urandom;
         op_a_i = a; op_b_i = b;
         exp = ref_mul(2'b11, a, b, 1'b0);
         @(negedge clk_i);
         n_checks++;
         if (valid_o !== 1'b1 || multdiv_result_o !== exp) begin
            n_fail++;
            $display("FAIL b2b_mull %0d: valid=%b result=%h, required valid=1 result=%h",
                     i, valid_o, multdiv_result_o, exp);
         end
         @(posedge clk_i); #1;
      end
      // MULH consumed with ready while enable stays high, then a second MULH directly
      operator_i = MD_OP_MULH; signed_mode_i = 2'b01;
      for (int i = 0; i < 2; i++) begin
         a = $urandom; b = $urandom;
         op_a_i = a; op_b_i = b; multdiv_ready_id_i = 1'b0;
         exp = ref_mul(2'b01, a, b, 1'b1);
         @(negedge clk_i);
         n_checks++;
         if (valid_o !== 1'b0 || imd_val_we_o !== 2'b01) begin
            n_fail++;
            $display("FAIL b2b_mulh_c0 %0d: valid=%b we=%b, required valid=0 we=01",
                     i, valid_o, imd_val_we_o);
         end
         @(posedge clk_i); #1;
         multdiv_ready_id_i = 1'b1;
         @(negedge clk_i);
         n_checks++;
         if (valid_o !== 1'b1 || multdiv_result_o !== exp) begin
            n_fail++;
            $display("FAIL b2b_mulh %0d: valid=%b result=%h, required valid=1 result=%h",
                     i, valid_o, multdiv_result_o, exp);
         end
         @(posedge clk_i); #1;
      end
      idle_inputs();
   endtask

   task automatic test_result_mux();
      @(posedge clk_i); #1;
      operator_i = MD_OP_MULL; signed_mode_i = 2'b00; op_a_i = 32'd7; op_b_i = 32'd6;
      mult_en_i = 1'b1; mult_sel_i = 1'b0; div_sel_i = 1'b0;
      @(negedge clk_i);
      n_checks++;
      if (multdiv_result_o !== 32'd0) begin
         n_fail++;
         $display("FAIL mux_none: result=%h, required 0", multdiv_result_o);
      end
      mult_sel_i = 1'b1;
      #1;
      n_checks++;
      if (multdiv_result_o !== 32'd42) begin
         n_fail++;
         $display("FAIL mux_mult: result=%h, required 2a", multdiv_result_o);
      end
      @(posedge clk_i); #1;
      idle_inputs();
   endtask

   task automatic start_div(input md_op_e op, input logic [1:0] mode, input logic [31:0] a,
                            input logic [31:0] b, input logic dit);
      operator_i = op; signed_mode_i = mode; op_a_i = a; op_b_i = b;
      data_ind_timing_i = dit; div_en_i = 1'b1; div_sel_i = 1'b1; multdiv_ready_id_i = 1'b0;
   endtask

   task automatic wait_div(input string name, input logic [31:0] exp, input int exp_lat);
      int lat;
      lat = -1;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk_i);
         if (valid_o === 1'b1) begin
            lat = c;
            break;
         end
      end
      n_checks++;
      if (lat != exp_lat) begin
         n_fail++;
         $display("FAIL %s latency: got %0d cycles, required %0d (-1 = timeout)",
                  name, lat, exp_lat);
      end
      n_checks++;
      if (multdiv_result_o !== exp) begin
         n_fail++;
         $display("FAIL %s result: got %h, required %h", name, multdiv_result_o, exp);
      end
      @(posedge clk_i); #1;
      multdiv_ready_id_i = 1'b1; div_en_i = 1'b0;
      @(posedge clk_i); #1;
      idle_inputs();
   endtask

   task automatic run_div(input string name, input md_op_e op, input logic [1:0] mode,
                          input logic [31:0] a, input logic [31:0] b, input logic dit);
      int exp_lat;
      exp_lat = (b == 32'd0 && !dit) ? 1 : 36;
      @(posedge clk_i); #1;
      start_div(op, mode, a, b, dit);
      wait_div(name, ref_div(op, mode, a, b), exp_lat);
   endtask

   task automatic test_div_directed();
      run_div("div_100_5",      MD_OP_DIV, 2'b00, 32'd100, 32'd5, 1'b0);
      run_div("div_m50_7",      MD_OP_DIV, 2'b11, -32'sd50, 32'd7, 1'b0);
      run_div("rem_m50_7",      MD_OP_REM, 2'b11, -32'sd50, 32'd7, 1'b0);
      run_div("div_42_0_fast",  MD_OP_DIV, 2'b00, 32'd42, 32'd0, 1'b0);
      run_div("div_42_0_dit",   MD_OP_DIV, 2'b00, 32'd42, 32'd0, 1'b1);
      run_div("rem_42_0_fast",  MD_OP_REM, 2'b00, 32'd42, 32'd0, 1'b0);
      run_div("rem_m42_0_dit",  MD_OP_REM, 2'b11, -32'sd42, 32'd0, 1'b1);
      run_div("div_m42_0_dit",  MD_OP_DIV, 2'b11, -32'sd42, 32'd0, 1'b1);
      run_div("div_0_42",       MD_OP_DIV, 2'b00, 32'd0, 32'd42, 1'b0);
      run_div("div_147_147",    MD_OP_DIV, 2'b00, 32'd147, 32'd147, 1'b0);
      run_div("div_ovf",        MD_OP_DIV, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_div("rem_ovf",        MD_OP_REM, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_div("divu_big",       MD_OP_DIV, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
      run_div("remu_big",       MD_OP_REM, 2'b00, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0);
   endtask

   task automatic test_div_random();
      logic [31:0] a, b;
      logic [1:0]  mode;
      md_op_e      op;
      logic        dit;
      for (int i = 0; i < 14; i++) begin
         a    = $urandom;
         b    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
         mode = 2'($urandom_range(0, 3));
         op   = ($urandom_range(0, 1) == 1) ? MD_OP_DIV : MD_OP_REM;
         dit  = 1'($urandom_range(0, 1));
         run_div("div_rand", op, mode, a, b, dit);
      end
   endtask

   task automatic test_div_abort();
      int n_valid;
      @(posedge clk_i); #1;
      start_div(MD_OP_DIV, 2'b00, 32'd1234, 32'd5, 1'b0);
      repeat (10) @(posedge clk_i);
      #1;
      div_en_i = 1'b0;
      n_valid = 0;
      repeat (45) begin
         @(negedge clk_i);
         if (valid_o === 1'b1) n_valid++;
      end
      n_checks++;
      if (n_valid != 0) begin
         n_fail++;
         $display("FAIL abort_no_result: valid seen %0d cycles, required 0", n_valid);
      end
      idle_inputs();
      run_div("div_after_abort", MD_OP_REM, 2'b11, -32'sd1000, 32'd33, 1'b0);
   endtask

   task automatic test_reset_mid_div();
      @(posedge clk_i); #1;
      start_div(MD_OP_DIV, 2'b00, 32'd1000, 32'd7, 1'b0);
      repeat (10) @(posedge clk_i);
      #1;
      rst_i = 1'b1;
      @(negedge clk_i);
      n_checks++;
      if (valid_o !== 1'b0 || imd_val_we_o !== 2'b00 || alu_operand_a_o !== 33'd0) begin
         n_fail++;
         $display("FAIL rst_mid_outputs: valid=%b we=%b opa=%h, required 0 00 0",
                  valid_o, imd_val_we_o, alu_operand_a_o);
      end
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      // enable is still high, so a full division restarts from idle right away
      wait_div("div_after_reset", 32'd142, 36);
      run_div("div_new_after_reset", MD_OP_DIV, 2'b11, 32'd77777, -32'sd123, 1'b1);
   endtask

   initial begin
      test_reset();
      test_mull();
      test_mulh();
      test_back_to_back();
      test_result_mux();
      test_div_directed();
      test_div_random();
      test_div_abort();
      test_reset_mid_div();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
